// File: rtl/cpl_enqueue_pkg.sv
// Shared types for the completion enqueue requester: slot lifecycle and slot payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpl_enqueue_pkg;

    localparam int CPL_QUEUE_W  = 5;
    localparam int CPL_DATA_W   = 128;
    localparam int CPL_ADDR_W   = 64;
    localparam int CPL_OP_TAG_W = 6;

    // The top bit of a completion record is overwritten with the queue phase.
    localparam int PHASE_BIT = CPL_DATA_W - 1;

    typedef enum logic [1:0] {
        SLOT_FREE   = 2'd0,
        SLOT_REQ    = 2'd1,
        SLOT_WRITE  = 2'd2,
        SLOT_COMMIT = 2'd3
    } slot_state_t;

    // Slot payload; field widths follow the package constants above.
    typedef struct packed {
        logic [CPL_QUEUE_W-1:0]  queue;
        logic [CPL_DATA_W-1:0]   data;
        logic [CPL_ADDR_W-1:0]   addr;
        logic [CPL_OP_TAG_W-1:0] op_tag;
        logic                    desc_issued;
    } slot_t;

endpackage

// File: rtl/cpl_slot_prio_enc.sv
// Lowest-set-bit priority encoder over a slot mask.
// Latency: combinational.
// Backpressure: none.
module cpl_slot_prio_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = i[IDX_W-1:0];
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpl_enqueue_requester.sv
// Takes completion records, requests CQ slots, DMA-writes each record, then commits the op.
// Latency: cpl accept -> req 1 cycle; resp -> DMA desc 1 cycle; write status -> commit 1 cycle.
// Backpressure: cpl_ready drops while a request is held or no slot is free; desc/commit held until ready.
module cpl_enqueue_requester
    import cpl_enqueue_pkg::*;
#(
    parameter int QUEUE_INDEX_WIDTH = CPL_QUEUE_W,
    parameter int SLOT_COUNT        = 8,
    parameter int REQ_TAG_WIDTH     = $clog2(SLOT_COUNT),
    parameter int OP_TAG_WIDTH      = CPL_OP_TAG_W,
    parameter int ADDR_WIDTH        = CPL_ADDR_W,
    parameter int CPL_WIDTH         = CPL_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_cpl_queue,
    input  logic [CPL_WIDTH-1:0]         s_axis_cpl_data,
    input  logic                         s_axis_cpl_valid,
    output logic                         s_axis_cpl_ready,
    output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_enqueue_req_queue,
    output logic [REQ_TAG_WIDTH-1:0]     m_axis_enqueue_req_tag,
    output logic                         m_axis_enqueue_req_valid,
    input  logic                         m_axis_enqueue_req_ready,
    input  logic [ADDR_WIDTH-1:0]        s_axis_enqueue_resp_addr,
    input  logic                         s_axis_enqueue_resp_phase,
    input  logic [REQ_TAG_WIDTH-1:0]     s_axis_enqueue_resp_tag,
    input  logic [OP_TAG_WIDTH-1:0]      s_axis_enqueue_resp_op_tag,
    input  logic                         s_axis_enqueue_resp_full,
    input  logic                         s_axis_enqueue_resp_error,
    input  logic                         s_axis_enqueue_resp_valid,
    output logic                         s_axis_enqueue_resp_ready,
    output logic [ADDR_WIDTH-1:0]        m_axis_dma_write_desc_addr,
    output logic [CPL_WIDTH-1:0]         m_axis_dma_write_desc_data,
    output logic [REQ_TAG_WIDTH-1:0]     m_axis_dma_write_desc_tag,
    output logic                         m_axis_dma_write_desc_valid,
    input  logic                         m_axis_dma_write_desc_ready,
    input  logic [REQ_TAG_WIDTH-1:0]     s_axis_dma_write_status_tag,
    input  logic                         s_axis_dma_write_status_valid,
    output logic [OP_TAG_WIDTH-1:0]      m_axis_enqueue_commit_op_tag,
    output logic                         m_axis_enqueue_commit_valid,
    input  logic                         m_axis_enqueue_commit_ready,
    output logic [31:0]                  stat_drop_count
);

    slot_state_t state_q [SLOT_COUNT];
    slot_state_t state_n [SLOT_COUNT];
    slot_state_t state_d [SLOT_COUNT];
    slot_t       slot_q  [SLOT_COUNT];
    slot_t       slot_n  [SLOT_COUNT];
    slot_t       slot_d  [SLOT_COUNT];

    logic                         cpl_rdy_q, cpl_rdy_d;
    logic                         resp_rdy_q;
    logic                         req_vld_q, req_vld_d;
    logic [QUEUE_INDEX_WIDTH-1:0] req_queue_q, req_queue_d;
    logic [REQ_TAG_WIDTH-1:0]     req_tag_q, req_tag_d;
    logic                         desc_vld_q, desc_vld_d;
    logic [ADDR_WIDTH-1:0]        desc_addr_q, desc_addr_d;
    logic [CPL_WIDTH-1:0]         desc_data_q, desc_data_d;
    logic [REQ_TAG_WIDTH-1:0]     desc_tag_q, desc_tag_d;
    logic                         commit_vld_q, commit_vld_d;
    logic [OP_TAG_WIDTH-1:0]      commit_op_tag_q, commit_op_tag_d;
    logic [REQ_TAG_WIDTH-1:0]     commit_tag_q, commit_tag_d;
    logic [31:0]                  drop_cnt_q, drop_cnt_d;

    logic [SLOT_COUNT-1:0]    free_mask, desc_mask, commit_mask;
    logic [REQ_TAG_WIDTH-1:0] alloc_idx, desc_idx, commit_idx;
    logic                     alloc_vld, desc_sel_vld, commit_sel_vld;
    logic                     cpl_fire, resp_fire, any_free;

    assign cpl_fire  = s_axis_cpl_valid && cpl_rdy_q && alloc_vld;
    assign resp_fire = s_axis_enqueue_resp_valid && resp_rdy_q;

    // Allocation looks only at registered state, so a slot freed this cycle is not reused yet.
    always_comb begin
        free_mask = '0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            free_mask[i] = (state_q[i] == SLOT_FREE);
        end
    end

    cpl_slot_prio_enc #(.WIDTH(SLOT_COUNT), .IDX_W(REQ_TAG_WIDTH)) u_alloc_enc (
        .req (free_mask),
        .idx (alloc_idx),
        .vld (alloc_vld)
    );

    // Apply this cycle's port events (commit done, write status, response, accept) to the slots.
    always_comb begin
        state_n     = state_q;
        slot_n      = slot_q;
        req_vld_d   = req_vld_q;
        req_queue_d = req_queue_q;
        req_tag_d   = req_tag_q;
        drop_cnt_d  = drop_cnt_q;

        if (req_vld_q && m_axis_enqueue_req_ready) begin
            req_vld_d = 1'b0;
        end
        if (commit_vld_q && m_axis_enqueue_commit_ready) begin
            state_n[commit_tag_q] = SLOT_FREE;
        end
        if (s_axis_dma_write_status_valid && state_q[s_axis_dma_write_status_tag] == SLOT_WRITE) begin
            state_n[s_axis_dma_write_status_tag] = SLOT_COMMIT;
        end
        if (resp_fire && state_q[s_axis_enqueue_resp_tag] == SLOT_REQ) begin
            if (s_axis_enqueue_resp_full || s_axis_enqueue_resp_error) begin
                state_n[s_axis_enqueue_resp_tag] = SLOT_FREE;
                if (drop_cnt_q != 32'hFFFF_FFFF) begin
                    drop_cnt_d = drop_cnt_q + 32'd1;
                end
            end else begin
                state_n[s_axis_enqueue_resp_tag]                = SLOT_WRITE;
                slot_n[s_axis_enqueue_resp_tag].addr            = s_axis_enqueue_resp_addr;
                slot_n[s_axis_enqueue_resp_tag].op_tag          = s_axis_enqueue_resp_op_tag;
                slot_n[s_axis_enqueue_resp_tag].data[PHASE_BIT] = s_axis_enqueue_resp_phase;
                slot_n[s_axis_enqueue_resp_tag].desc_issued     = 1'b0;
            end
        end
        if (cpl_fire) begin
            state_n[alloc_idx]             = SLOT_REQ;
            slot_n[alloc_idx].queue        = s_axis_cpl_queue;
            slot_n[alloc_idx].data         = s_axis_cpl_data;
            slot_n[alloc_idx].desc_issued  = 1'b0;
            req_vld_d   = 1'b1;
            req_queue_d = s_axis_cpl_queue;
            req_tag_d   = alloc_idx;
        end
    end

    // Select candidates from the updated view so a response/status shows up one cycle later.
    always_comb begin
        desc_mask   = '0;
        commit_mask = '0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            desc_mask[i]   = (state_n[i] == SLOT_WRITE) && !slot_n[i].desc_issued;
            commit_mask[i] = (state_n[i] == SLOT_COMMIT);
        end
    end

    cpl_slot_prio_enc #(.WIDTH(SLOT_COUNT), .IDX_W(REQ_TAG_WIDTH)) u_desc_enc (
        .req (desc_mask),
        .idx (desc_idx),
        .vld (desc_sel_vld)
    );

    cpl_slot_prio_enc #(.WIDTH(SLOT_COUNT), .IDX_W(REQ_TAG_WIDTH)) u_commit_enc (
        .req (commit_mask),
        .idx (commit_idx),
        .vld (commit_sel_vld)
    );

    // Reload the DMA and commit output registers whenever they are empty or draining.
    always_comb begin
        state_d         = state_n;
        slot_d          = slot_n;
        desc_vld_d      = desc_vld_q;
        desc_addr_d     = desc_addr_q;
        desc_data_d     = desc_data_q;
        desc_tag_d      = desc_tag_q;
        commit_vld_d    = commit_vld_q;
        commit_op_tag_d = commit_op_tag_q;
        commit_tag_d    = commit_tag_q;
        any_free        = 1'b0;

        if (!desc_vld_q || m_axis_dma_write_desc_ready) begin
            desc_vld_d = desc_sel_vld;
            if (desc_sel_vld) begin
                desc_addr_d                  = slot_n[desc_idx].addr;
                desc_data_d                  = slot_n[desc_idx].data;
                desc_tag_d                   = desc_idx;
                slot_d[desc_idx].desc_issued = 1'b1;
            end
        end
        // The held commit slot is freed in state_n on handshake, so it is never picked twice.
        if (!commit_vld_q || m_axis_enqueue_commit_ready) begin
            commit_vld_d = commit_sel_vld;
            if (commit_sel_vld) begin
                commit_op_tag_d = slot_n[commit_idx].op_tag;
                commit_tag_d    = commit_idx;
            end
        end
        for (int i = 0; i < SLOT_COUNT; i++) begin
            if (state_n[i] == SLOT_FREE) begin
                any_free = 1'b1;
            end
        end
        cpl_rdy_d = any_free && !req_vld_d;
    end

    // State and output registers; reset drops every slot and every pending output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOT_COUNT; i++) begin
                state_q[i] <= SLOT_FREE;
                slot_q[i]  <= '0;
            end
            cpl_rdy_q       <= 1'b0;
            resp_rdy_q      <= 1'b0;
            req_vld_q       <= 1'b0;
            req_queue_q     <= '0;
            req_tag_q       <= '0;
            desc_vld_q      <= 1'b0;
            desc_addr_q     <= '0;
            desc_data_q     <= '0;
            desc_tag_q      <= '0;
            commit_vld_q    <= 1'b0;
            commit_op_tag_q <= '0;
            commit_tag_q    <= '0;
            drop_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            slot_q          <= slot_d;
            cpl_rdy_q       <= cpl_rdy_d;
            resp_rdy_q      <= 1'b1;
            req_vld_q       <= req_vld_d;
            req_queue_q     <= req_queue_d;
            req_tag_q       <= req_tag_d;
            desc_vld_q      <= desc_vld_d;
            desc_addr_q     <= desc_addr_d;
            desc_data_q     <= desc_data_d;
            desc_tag_q      <= desc_tag_d;
            commit_vld_q    <= commit_vld_d;
            commit_op_tag_q <= commit_op_tag_d;
            commit_tag_q    <= commit_tag_d;
            drop_cnt_q      <= drop_cnt_d;
        end
    end

    assign s_axis_cpl_ready             = cpl_rdy_q;
    assign s_axis_enqueue_resp_ready    = resp_rdy_q;
    assign m_axis_enqueue_req_valid     = req_vld_q;
    assign m_axis_enqueue_req_queue     = req_queue_q;
    assign m_axis_enqueue_req_tag       = req_tag_q;
    assign m_axis_dma_write_desc_valid  = desc_vld_q;
    assign m_axis_dma_write_desc_addr   = desc_addr_q;
    assign m_axis_dma_write_desc_data   = desc_data_q;
    assign m_axis_dma_write_desc_tag    = desc_tag_q;
    assign m_axis_enqueue_commit_valid  = commit_vld_q;
    assign m_axis_enqueue_commit_op_tag = commit_op_tag_q;
    assign stat_drop_count              = drop_cnt_q;

endmodule

// File: tb/tb_cpl_enqueue_requester.sv
// Directed bench for cpl_enqueue_requester: one task per scenario with inline checks.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Every wait on the DUT is bounded and a timeout is reported as a failed check.
module tb_cpl_enqueue_requester;

    localparam int QIW = 5;
    localparam int RTW = 3;
    localparam int OTW = 6;
    localparam int AW  = 64;
    localparam int CW  = 128;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [QIW-1:0] s_axis_cpl_queue = '0;
    logic [CW-1:0]  s_axis_cpl_data = '0;
    logic           s_axis_cpl_valid = 1'b0;
    logic           s_axis_cpl_ready;
    logic [QIW-1:0] m_axis_enqueue_req_queue;
    logic [RTW-1:0] m_axis_enqueue_req_tag;
    logic           m_axis_enqueue_req_valid;
    logic           m_axis_enqueue_req_ready = 1'b0;
    logic [AW-1:0]  s_axis_enqueue_resp_addr = '0;
    logic           s_axis_enqueue_resp_phase = 1'b0;
    logic [RTW-1:0] s_axis_enqueue_resp_tag = '0;
    logic [OTW-1:0] s_axis_enqueue_resp_op_tag = '0;
    logic           s_axis_enqueue_resp_full = 1'b0;
    logic           s_axis_enqueue_resp_error = 1'b0;
    logic           s_axis_enqueue_resp_valid = 1'b0;
    logic           s_axis_enqueue_resp_ready;
    logic [AW-1:0]  m_axis_dma_write_desc_addr;
    logic [CW-1:0]  m_axis_dma_write_desc_data;
    logic [RTW-1:0] m_axis_dma_write_desc_tag;
    logic           m_axis_dma_write_desc_valid;
    logic           m_axis_dma_write_desc_ready = 1'b0;
    logic [RTW-1:0] s_axis_dma_write_status_tag = '0;
    logic           s_axis_dma_write_status_valid = 1'b0;
    logic [OTW-1:0] m_axis_enqueue_commit_op_tag;
    logic           m_axis_enqueue_commit_valid;
    logic           m_axis_enqueue_commit_ready = 1'b0;
    logic [31:0]    stat_drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpl_enqueue_requester dut (
        .clk                           (clk),
        .rst                           (rst),
        .s_axis_cpl_queue              (s_axis_cpl_queue),
        .s_axis_cpl_data               (s_axis_cpl_data),
        .s_axis_cpl_valid              (s_axis_cpl_valid),
        .s_axis_cpl_ready              (s_axis_cpl_ready),
        .m_axis_enqueue_req_queue      (m_axis_enqueue_req_queue),
        .m_axis_enqueue_req_tag        (m_axis_enqueue_req_tag),
        .m_axis_enqueue_req_valid      (m_axis_enqueue_req_valid),
        .m_axis_enqueue_req_ready      (m_axis_enqueue_req_ready),
        .s_axis_enqueue_resp_addr      (s_axis_enqueue_resp_addr),
        .s_axis_enqueue_resp_phase     (s_axis_enqueue_resp_phase),
        .s_axis_enqueue_resp_tag       (s_axis_enqueue_resp_tag),
        .s_axis_enqueue_resp_op_tag    (s_axis_enqueue_resp_op_tag),
        .s_axis_enqueue_resp_full      (s_axis_enqueue_resp_full),
        .s_axis_enqueue_resp_error     (s_axis_enqueue_resp_error),
        .s_axis_enqueue_resp_valid     (s_axis_enqueue_resp_valid),
        .s_axis_enqueue_resp_ready     (s_axis_enqueue_resp_ready),
        .m_axis_dma_write_desc_addr    (m_axis_dma_write_desc_addr),
        .m_axis_dma_write_desc_data    (m_axis_dma_write_desc_data),
        .m_axis_dma_write_desc_tag     (m_axis_dma_write_desc_tag),
        .m_axis_dma_write_desc_valid   (m_axis_dma_write_desc_valid),
        .m_axis_dma_write_desc_ready   (m_axis_dma_write_desc_ready),
        .s_axis_dma_write_status_tag   (s_axis_dma_write_status_tag),
        .s_axis_dma_write_status_valid (s_axis_dma_write_status_valid),
        .m_axis_enqueue_commit_op_tag  (m_axis_enqueue_commit_op_tag),
        .m_axis_enqueue_commit_valid   (m_axis_enqueue_commit_valid),
        .m_axis_enqueue_commit_ready   (m_axis_enqueue_commit_ready),
        .stat_drop_count               (stat_drop_count)
    );

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] fill_data(input int t);
        logic [CW-1:0] d;
        d = 128'h0055_0000_0000_0000_0000_0000_0000_0000 + 128'(t);
        return d;
    endfunction

    task automatic send_cpl(input logic [QIW-1:0] q, input logic [CW-1:0] d, output bit ok);
        s_axis_cpl_queue = q;
        s_axis_cpl_data  = d;
        s_axis_cpl_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (s_axis_cpl_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        s_axis_cpl_valid = 1'b0;
    endtask

    task automatic take_req(output logic [RTW-1:0] tag, output bit ok);
        ok  = 1'b0;
        tag = '0;
        for (int i = 0; i < 50; i++) begin
            if (m_axis_enqueue_req_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            tag = m_axis_enqueue_req_tag;
            m_axis_enqueue_req_ready = 1'b1;
            tick();
            m_axis_enqueue_req_ready = 1'b0;
        end
    endtask

    task automatic alloc_one(input logic [QIW-1:0] q, input logic [CW-1:0] d,
                             output logic [RTW-1:0] tag, output bit ok);
        bit ok_a, ok_b;
        send_cpl(q, d, ok_a);
        take_req(tag, ok_b);
        ok = ok_a && ok_b;
    endtask

    task automatic send_resp(input logic [RTW-1:0] tag, input logic [AW-1:0] addr, input logic phase,
                             input logic [OTW-1:0] op, input logic full, input logic err);
        s_axis_enqueue_resp_tag    = tag;
        s_axis_enqueue_resp_addr   = addr;
        s_axis_enqueue_resp_phase  = phase;
        s_axis_enqueue_resp_op_tag = op;
        s_axis_enqueue_resp_full   = full;
        s_axis_enqueue_resp_error  = err;
        s_axis_enqueue_resp_valid  = 1'b1;
        tick();
        s_axis_enqueue_resp_valid  = 1'b0;
        s_axis_enqueue_resp_full   = 1'b0;
        s_axis_enqueue_resp_error  = 1'b0;
    endtask

    task automatic send_status(input logic [RTW-1:0] tag);
        s_axis_dma_write_status_tag   = tag;
        s_axis_dma_write_status_valid = 1'b1;
        tick();
        s_axis_dma_write_status_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (s_axis_cpl_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cpl_ready: got %b want 0", s_axis_cpl_ready); end
        n_cmp++; if (s_axis_enqueue_resp_ready !== 1'b0) begin n_bad++; $display("FAIL reset_resp_ready: got %b want 0", s_axis_enqueue_resp_ready); end
        n_cmp++; if (m_axis_enqueue_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", m_axis_enqueue_req_valid); end
        n_cmp++; if (m_axis_dma_write_desc_valid !== 1'b0) begin n_bad++; $display("FAIL reset_desc_valid: got %b want 0", m_axis_dma_write_desc_valid); end
        n_cmp++; if (m_axis_enqueue_commit_valid !== 1'b0) begin n_bad++; $display("FAIL reset_commit_valid: got %b want 0", m_axis_enqueue_commit_valid); end
        n_cmp++; if (stat_drop_count !== 32'd0) begin n_bad++; $display("FAIL reset_drop_count: got %0d want 0", stat_drop_count); end
        n_cmp++; if (m_axis_dma_write_desc_data !== '0) begin n_bad++; $display("FAIL reset_desc_data: got %h want 0", m_axis_dma_write_desc_data); end
        rst = 1'b0;
        tick();
        n_cmp++; if (s_axis_cpl_ready !== 1'b1) begin n_bad++; $display("FAIL idle_cpl_ready: got %b want 1", s_axis_cpl_ready); end
        n_cmp++; if (s_axis_enqueue_resp_ready !== 1'b1) begin n_bad++; $display("FAIL idle_resp_ready: got %b want 1", s_axis_enqueue_resp_ready); end
    endtask

    task automatic test_single();
        bit ok;
        logic [CW-1:0] d  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66AB;
        logic [CW-1:0] dp = 128'h8123_4567_89AB_CDEF_0011_2233_4455_66AB;
        send_cpl(5'd3, d, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_accept: got timeout want accept"); end
        n_cmp++; if (m_axis_enqueue_req_valid !== 1'b1) begin n_bad++; $display("FAIL single_req_latency: got %b want 1", m_axis_enqueue_req_valid); end
        n_cmp++; if (m_axis_enqueue_req_tag !== 3'd0) begin n_bad++; $display("FAIL single_req_tag: got %0d want 0", m_axis_enqueue_req_tag); end
        n_cmp++; if (m_axis_enqueue_req_queue !== 5'd3) begin n_bad++; $display("FAIL single_req_queue: got %0d want 3", m_axis_enqueue_req_queue); end
        m_axis_enqueue_req_ready = 1'b1;
        tick();
        m_axis_enqueue_req_ready = 1'b0;
        send_resp(3'd0, 64'h1000, 1'b1, 6'h15, 1'b0, 1'b0);
        n_cmp++; if (m_axis_dma_write_desc_valid !== 1'b1) begin n_bad++; $display("FAIL single_desc_latency: got %b want 1", m_axis_dma_write_desc_valid); end
        n_cmp++; if (m_axis_dma_write_desc_addr !== 64'h1000) begin n_bad++; $display("FAIL single_desc_addr: got %h want 1000", m_axis_dma_write_desc_addr); end
        n_cmp++; if (m_axis_dma_write_desc_data !== dp) begin n_bad++; $display("FAIL single_desc_data: got %h want %h", m_axis_dma_write_desc_data, dp); end
        n_cmp++; if (m_axis_dma_write_desc_tag !== 3'd0) begin n_bad++; $display("FAIL single_desc_tag: got %0d want 0", m_axis_dma_write_desc_tag); end
        m_axis_dma_write_desc_ready = 1'b1;
        tick();
        m_axis_dma_write_desc_ready = 1'b0;
        n_cmp++; if (m_axis_dma_write_desc_valid !== 1'b0) begin n_bad++; $display("FAIL single_desc_drained: got %b want 0", m_axis_dma_write_desc_valid); end
        send_status(3'd0);
        n_cmp++; if (m_axis_enqueue_commit_valid !== 1'b1) begin n_bad++; $display("FAIL single_commit_latency: got %b want 1", m_axis_enqueue_commit_valid); end
        n_cmp++; if (m_axis_enqueue_commit_op_tag !== 6'h15) begin n_bad++; $display("FAIL single_commit_op: got %h want 15", m_axis_enqueue_commit_op_tag); end
        m_axis_enqueue_commit_ready = 1'b1;
        tick();
        m_axis_enqueue_commit_ready = 1'b0;
        n_cmp++; if (m_axis_enqueue_commit_valid !== 1'b0) begin n_bad++; $display("FAIL single_commit_drained: got %b want 0", m_axis_enqueue_commit_valid); end
        n_cmp++; if (s_axis_cpl_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_after: got %b want 1", s_axis_cpl_ready); end
    endtask

    task automatic test_drop();
        bit ok;
        logic [RTW-1:0] tag;
        alloc_one(5'd5, 128'h77, tag, ok);
        n_cmp++; if (!ok || tag !== 3'd0) begin n_bad++; $display("FAIL drop_alloc1: got ok=%b tag=%0d want ok=1 tag=0", ok, tag); end
        send_resp(tag, 64'h2000, 1'b0, 6'h01, 1'b1, 1'b0);
        tick(); tick(); tick();
        n_cmp++; if (m_axis_dma_write_desc_valid !== 1'b0) begin n_bad++; $display("FAIL drop_full_desc: got %b want 0", m_axis_dma_write_desc_valid); end
        n_cmp++; if (m_axis_enqueue_commit_valid !== 1'b0) begin n_bad++; $display("FAIL drop_full_commit: got %b want 0", m_axis_enqueue_commit_valid); end
        n_cmp++; if (stat_drop_count !== 32'd1) begin n_bad++; $display("FAIL drop_count1: got %0d want 1", stat_drop_count); end
        alloc_one(5'd6, 128'h78, tag, ok);
        n_cmp++; if (!ok || tag !== 3'd0) begin n_bad++; $display("FAIL drop_alloc2: got ok=%b tag=%0d want ok=1 tag=0", ok, tag); end
        send_resp(tag, 64'h2100, 1'b1, 6'h02, 1'b0, 1'b1);
        tick(); tick();
        n_cmp++; if (stat_drop_count !== 32'd2) begin n_bad++; $display("FAIL drop_count2: got %0d want 2", stat_drop_count); end
        n_cmp++; if (m_axis_dma_write_desc_valid !== 1'b0 || m_axis_enqueue_commit_valid !== 1'b0) begin n_bad++; $display("FAIL drop_err_outputs: got desc=%b commit=%b want 0 0", m_axis_dma_write_desc_valid, m_axis_enqueue_commit_valid); end
    endtask

    task automatic test_fill_and_stall();
        bit ok, stable;
        logic [RTW-1:0] tag;
        int order [8] = '{7, 0, 1, 2, 3, 4, 5, 6};
        logic [CW-1:0] exp_d;
        int e;
        for (int i = 0; i < 8; i++) begin
            alloc_one(QIW'(i), fill_data(i), tag, ok);
            n_cmp++; if (!ok || tag !== RTW'(i)) begin n_bad++; $display("FAIL fill_alloc%0d: got ok=%b tag=%0d want ok=1 tag=%0d", i, ok, tag, i); end
        end
        tick();
        n_cmp++; if (s_axis_cpl_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready_low: got %b want 0", s_axis_cpl_ready); end
        for (int t = 7; t >= 0; t--) begin
            send_resp(RTW'(t), 64'h3000 + 64'(t * 16), t[0], OTW'(32 + t), 1'b0, 1'b0);
        end
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (m_axis_dma_write_desc_valid !== 1'b1 || m_axis_dma_write_desc_tag !== 3'd7) stable = 1'b0;
            tick();
        end
        n_cmp++; if (!stable) begin n_bad++; $display("FAIL desc_stall_stable: got tag=%0d valid=%b want held tag 7", m_axis_dma_write_desc_tag, m_axis_dma_write_desc_valid); end
        m_axis_dma_write_desc_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = order[k];
            for (int w = 0; w < 20 && !m_axis_dma_write_desc_valid; w++) tick();
            exp_d = fill_data(e);
            exp_d[127] = e[0];
            n_cmp++; if (m_axis_dma_write_desc_valid !== 1'b1 || m_axis_dma_write_desc_tag !== RTW'(e)) begin n_bad++; $display("FAIL desc_order%0d: got valid=%b tag=%0d want tag %0d", k, m_axis_dma_write_desc_valid, m_axis_dma_write_desc_tag, e); end
            n_cmp++; if (m_axis_dma_write_desc_addr !== 64'h3000 + 64'(e * 16) || m_axis_dma_write_desc_data !== exp_d) begin n_bad++; $display("FAIL desc_payload%0d: got addr=%h data=%h want addr=%h data=%h", k, m_axis_dma_write_desc_addr, m_axis_dma_write_desc_data, 64'h3000 + 64'(e * 16), exp_d); end
            tick();
        end
        m_axis_dma_write_desc_ready = 1'b0;
        for (int t = 7; t >= 0; t--) begin
            send_status(RTW'(t));
        end
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (m_axis_enqueue_commit_valid !== 1'b1 || m_axis_enqueue_commit_op_tag !== 6'h27) stable = 1'b0;
            tick();
        end
        n_cmp++; if (!stable) begin n_bad++; $display("FAIL commit_stall_stable: got op=%h valid=%b want held 27", m_axis_enqueue_commit_op_tag, m_axis_enqueue_commit_valid); end
        m_axis_enqueue_commit_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = order[k];
            for (int w = 0; w < 20 && !m_axis_enqueue_commit_valid; w++) tick();
            n_cmp++; if (m_axis_enqueue_commit_valid !== 1'b1 || m_axis_enqueue_commit_op_tag !== OTW'(32 + e)) begin n_bad++; $display("FAIL commit_order%0d: got valid=%b op=%h want op %h", k, m_axis_enqueue_commit_valid, m_axis_enqueue_commit_op_tag, OTW'(32 + e)); end
            tick();
        end
        m_axis_enqueue_commit_ready = 1'b0;
        n_cmp++; if (m_axis_enqueue_commit_valid !== 1'b0 || s_axis_cpl_ready !== 1'b1) begin n_bad++; $display("FAIL fill_drained: got commit=%b ready=%b want 0 1", m_axis_enqueue_commit_valid, s_axis_cpl_ready); end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        logic [RTW-1:0] tag;
        for (int i = 0; i < 4; i++) alloc_one(QIW'(i), fill_data(16 + i), tag, ok);
        send_resp(3'd0, 64'h4000, 1'b0, 6'h30, 1'b0, 1'b0);
        send_resp(3'd1, 64'h4010, 1'b1, 6'h31, 1'b0, 1'b0);
        m_axis_dma_write_desc_ready = 1'b1;
        tick();
        m_axis_dma_write_desc_ready = 1'b0;
        send_status(3'd0);
        n_cmp++; if (m_axis_dma_write_desc_valid !== 1'b1 || m_axis_enqueue_commit_valid !== 1'b1) begin n_bad++; $display("FAIL mid_setup: got desc=%b commit=%b want 1 1", m_axis_dma_write_desc_valid, m_axis_enqueue_commit_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (m_axis_dma_write_desc_valid !== 1'b0 || m_axis_enqueue_commit_valid !== 1'b0 || m_axis_enqueue_req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valids: got desc=%b commit=%b req=%b want 0 0 0", m_axis_dma_write_desc_valid, m_axis_enqueue_commit_valid, m_axis_enqueue_req_valid); end
        n_cmp++; if (m_axis_dma_write_desc_addr !== '0 || m_axis_dma_write_desc_tag !== '0 || m_axis_enqueue_commit_op_tag !== '0) begin n_bad++; $display("FAIL mid_rst_data: got addr=%h tag=%0d op=%h want 0 0 0", m_axis_dma_write_desc_addr, m_axis_dma_write_desc_tag, m_axis_enqueue_commit_op_tag); end
        n_cmp++; if (stat_drop_count !== 32'd0 || s_axis_cpl_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_misc: got drop=%0d ready=%b want 0 0", stat_drop_count, s_axis_cpl_ready); end
        tick();
        tick();
        m_axis_dma_write_desc_ready = 1'b1;
        m_axis_enqueue_commit_ready = 1'b1;
        send_status(3'd1);
        send_resp(3'd2, 64'h5000, 1'b1, 6'h32, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (m_axis_dma_write_desc_valid || m_axis_enqueue_commit_valid) seen = 1'b1;
            tick();
        end
        m_axis_dma_write_desc_ready = 1'b0;
        m_axis_enqueue_commit_ready = 1'b0;
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_stale_ignored: got activity=%b want 0", seen); end
        alloc_one(5'd9, 128'h1, tag, ok);
        n_cmp++; if (!ok || tag !== 3'd0) begin n_bad++; $display("FAIL mid_realloc: got ok=%b tag=%0d want ok=1 tag=0", ok, tag); end
    endtask

    task automatic test_same_cycle();
        bit ok;
        logic [RTW-1:0] tag;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        alloc_one(5'd1, 128'hA0, tag, ok);
        alloc_one(5'd2, 128'hB0, tag, ok);
        send_resp(3'd0, 64'h6000, 1'b1, 6'h3A, 1'b0, 1'b0);
        m_axis_dma_write_desc_ready = 1'b1;
        tick();
        m_axis_dma_write_desc_ready = 1'b0;
        n_cmp++; if (s_axis_cpl_ready !== 1'b1) begin n_bad++; $display("FAIL same_pre_ready: got %b want 1", s_axis_cpl_ready); end
        s_axis_cpl_queue = 5'd7;
        s_axis_cpl_data  = 128'hC0;
        s_axis_cpl_valid = 1'b1;
        s_axis_enqueue_resp_tag    = 3'd1;
        s_axis_enqueue_resp_addr   = 64'h6100;
        s_axis_enqueue_resp_phase  = 1'b0;
        s_axis_enqueue_resp_op_tag = 6'h3B;
        s_axis_enqueue_resp_valid  = 1'b1;
        s_axis_dma_write_status_tag   = 3'd0;
        s_axis_dma_write_status_valid = 1'b1;
        tick();
        s_axis_cpl_valid = 1'b0;
        s_axis_enqueue_resp_valid = 1'b0;
        s_axis_dma_write_status_valid = 1'b0;
        n_cmp++; if (m_axis_enqueue_req_valid !== 1'b1 || m_axis_enqueue_req_tag !== 3'd2 || m_axis_enqueue_req_queue !== 5'd7) begin n_bad++; $display("FAIL same_alloc: got valid=%b tag=%0d q=%0d want 1 2 7", m_axis_enqueue_req_valid, m_axis_enqueue_req_tag, m_axis_enqueue_req_queue); end
        n_cmp++; if (m_axis_dma_write_desc_valid !== 1'b1 || m_axis_dma_write_desc_tag !== 3'd1 || m_axis_dma_write_desc_addr !== 64'h6100) begin n_bad++; $display("FAIL same_desc: got valid=%b tag=%0d addr=%h want 1 1 6100", m_axis_dma_write_desc_valid, m_axis_dma_write_desc_tag, m_axis_dma_write_desc_addr); end
        n_cmp++; if (m_axis_enqueue_commit_valid !== 1'b1 || m_axis_enqueue_commit_op_tag !== 6'h3A) begin n_bad++; $display("FAIL same_commit: got valid=%b op=%h want 1 3a", m_axis_enqueue_commit_valid, m_axis_enqueue_commit_op_tag); end
        m_axis_enqueue_req_ready = 1'b1;
        tick();
        m_axis_enqueue_req_ready = 1'b0;
        n_cmp++; if (s_axis_cpl_ready !== 1'b1) begin n_bad++; $display("FAIL same_ready_again: got %b want 1", s_axis_cpl_ready); end
        s_axis_cpl_queue = 5'd4;
        s_axis_cpl_data  = 128'hD0;
        s_axis_cpl_valid = 1'b1;
        m_axis_enqueue_commit_ready = 1'b1;
        tick();
        s_axis_cpl_valid = 1'b0;
        m_axis_enqueue_commit_ready = 1'b0;
        n_cmp++; if (m_axis_enqueue_req_valid !== 1'b1 || m_axis_enqueue_req_tag !== 3'd3) begin n_bad++; $display("FAIL free_alloc_same_cycle: got valid=%b tag=%0d want 1 3", m_axis_enqueue_req_valid, m_axis_enqueue_req_tag); end
        n_cmp++; if (m_axis_enqueue_commit_valid !== 1'b0) begin n_bad++; $display("FAIL free_commit_done: got %b want 0", m_axis_enqueue_commit_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_drop();
        test_fill_and_stall();
        test_reset_mid();
        test_same_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
